// File: rtl/a_buffer_loader_if.sv
// A-buffer loader bus: start/size config, element stream in, buffer write port out.
// Latency: n/a (signal bundle only).
// Backpressure: s_ready from the loader. The buffer side has no ready and is never stalled.
// Ports: start_i/m_i/n_i (config), s_valid/s_data/s_last/s_ready (element stream),
//        a_wr_en/a_wr_addr/a_wr_data/a_wr_lane_en (buffer write), busy/done/err (status).
interface a_buffer_loader_if #(
   parameter int ARRAY_HEIGHT         = 4,
   parameter int DATA_WIDTH           = 16,
   parameter int BUFFER_ADDRESS_WIDTH = 10
);
   logic                               start_i;
   logic [15:0]                        m_i;
   logic [15:0]                        n_i;
   logic                               s_valid;
   logic [DATA_WIDTH-1:0]              s_data;
   logic                               s_last;
   logic                               s_ready;
   logic                               a_wr_en;
   logic [BUFFER_ADDRESS_WIDTH-1:0]    a_wr_addr;
   logic [ARRAY_HEIGHT*DATA_WIDTH-1:0] a_wr_data;
   logic [ARRAY_HEIGHT-1:0]            a_wr_lane_en;
   logic                               busy;
   logic                               done;
   logic                               err;

   // Loader side.
   modport slave (
      input  start_i, m_i, n_i, s_valid, s_data, s_last,
      output s_ready, a_wr_en, a_wr_addr, a_wr_data, a_wr_lane_en, busy, done, err
   );

   // Host / DMA side.
   modport master (
      output start_i, m_i, n_i, s_valid, s_data, s_last,
      input  s_ready, a_wr_en, a_wr_addr, a_wr_data, a_wr_lane_en, busy, done, err
   );
endinterface

// File: rtl/a_buffer_loader.sv
// Scatters a row-major m x n element stream into the A buffer: word (row/H)*n+col, lane row%H.
// Latency: 1 cycle from an accepted beat to its buffer write. done comes with the final write.
// Backpressure: s_ready is high for the whole load. The buffer never stalls, so the rate is 1 element/cycle.
// Ports: clk, reset (async, active-high), io_bus (a_buffer_loader_if.slave).
module a_buffer_loader #(
   parameter int ARRAY_HEIGHT         = 4,
   parameter int DATA_WIDTH           = 16,
   parameter int BUFFER_ADDRESS_WIDTH = 10
) (
   input  logic            clk,
   input  logic            reset,
   a_buffer_loader_if.slave io_bus
);
   localparam int LANE_W = $clog2(ARRAY_HEIGHT);

   typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_m, w_m_nxt;
   logic [15:0] r_n, w_n_nxt;
   logic [15:0] r_col, w_col_nxt;
   logic [15:0] r_row, w_row_nxt;
   logic [15:0] r_base, w_base_nxt;
   logic        r_err, w_err_nxt;
   logic        r_done, w_done_nxt;
   logic        w_wr_en_nxt;

   logic                               r_wr_en;
   logic [BUFFER_ADDRESS_WIDTH-1:0]    r_wr_addr;
   logic [ARRAY_HEIGHT*DATA_WIDTH-1:0] r_wr_data;
   logic [ARRAY_HEIGHT-1:0]            r_wr_lane_en;

   logic        w_accept;
   logic        w_last_col;
   logic        w_final_beat;
   logic [15:0] w_addr_full;

   assign w_accept     = (r_state == LOAD) && io_bus.s_valid;
   assign w_last_col   = (r_col == r_n - 16'd1);
   assign w_final_beat = w_last_col && (r_row == r_m - 16'd1);
   // 16-bit address sum, truncated to the buffer width below.
   assign w_addr_full  = r_base + r_col;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_m     <= '0;
         r_n     <= '0;
         r_col   <= '0;
         r_row   <= '0;
         r_base  <= '0;
         r_err   <= 1'b0;
         r_done  <= 1'b0;
         r_wr_en <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_m     <= w_m_nxt;
         r_n     <= w_n_nxt;
         r_col   <= w_col_nxt;
         r_row   <= w_row_nxt;
         r_base  <= w_base_nxt;
         r_err   <= w_err_nxt;
         r_done  <= w_done_nxt;
         r_wr_en <= w_wr_en_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_m_nxt     = r_m;
      w_n_nxt     = r_n;
      w_col_nxt   = r_col;
      w_row_nxt   = r_row;
      w_base_nxt  = r_base;
      w_err_nxt   = r_err;
      w_done_nxt  = 1'b0;
      w_wr_en_nxt = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (io_bus.start_i) begin
               if ((io_bus.m_i != 16'd0) && (io_bus.n_i != 16'd0)) begin
                  w_state_nxt = LOAD;
                  w_m_nxt     = io_bus.m_i;
                  w_n_nxt     = io_bus.n_i;
                  w_col_nxt   = '0;
                  w_row_nxt   = '0;
                  w_base_nxt  = '0;
                  w_err_nxt   = 1'b0;
               end else begin
                  // Empty matrix: report completion with no writes.
                  w_done_nxt = 1'b1;
               end
            end
         end
         LOAD: begin
            if (w_accept) begin
               w_wr_en_nxt = 1'b1;
               if (w_last_col) begin
                  w_col_nxt = '0;
                  w_row_nxt = r_row + 16'd1;
                  // Leaving the top lane of a word group: the next row group starts n words on.
                  if (r_row[LANE_W-1:0] == {LANE_W{1'b1}}) begin
                     w_base_nxt = r_base + r_n;
                  end
               end else begin
                  w_col_nxt = r_col + 16'd1;
               end
               // Sender's last marker must coincide with the counted final beat.
               if (io_bus.s_last != w_final_beat) begin
                  w_err_nxt = 1'b1;
               end
               if (w_final_beat) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
      endcase
   end

   // Write payload. Held between writes. Only a_wr_en marks it meaningful.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_wr_lane_en <= '0;
      end else if (w_accept) begin
         r_wr_addr    <= w_addr_full[BUFFER_ADDRESS_WIDTH-1:0];
         r_wr_data    <= {ARRAY_HEIGHT{io_bus.s_data}};
         r_wr_lane_en <= ARRAY_HEIGHT'(1) << r_row[LANE_W-1:0];
      end
   end

   assign io_bus.s_ready      = (r_state == LOAD);
   assign io_bus.busy         = (r_state == LOAD);
   assign io_bus.a_wr_en      = r_wr_en;
   assign io_bus.a_wr_addr    = r_wr_addr;
   assign io_bus.a_wr_data    = r_wr_data;
   assign io_bus.a_wr_lane_en = r_wr_lane_en;
   assign io_bus.done         = r_done;
   assign io_bus.err          = r_err;
endmodule

// File: tb/tb_a_buffer_loader.sv
// Testbench for a_buffer_loader. It predicts every buffer write from matrix coordinates.
// Latency: writes are expected one cycle after acceptance and are compared at each negedge.
// Backpressure: the stream is driven with and without s_valid gaps.
module tb_a_buffer_loader;
   localparam int H   = 4;
   localparam int DW  = 16;
   localparam int BAW = 10;
   localparam int NE  = 512;

   logic clk = 1'b0;
   logic reset;

   a_buffer_loader_if #(.ARRAY_HEIGHT(H), .DATA_WIDTH(DW), .BUFFER_ADDRESS_WIDTH(BAW)) bus ();

   a_buffer_loader #(.ARRAY_HEIGHT(H), .DATA_WIDTH(DW), .BUFFER_ADDRESS_WIDTH(BAW)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // Expected writes: filled by the driver, consumed by the compare loop.
   logic [BAW-1:0]  e_addr [NE];
   logic [H-1:0]    e_lane [NE];
   logic [H*DW-1:0] e_data [NE];
   logic            e_fin  [NE];
   logic            e_err  [NE];
   int push_idx = 0;
   int pop_idx  = 0;
   logic model_err = 1'b0;
   logic allow_done = 1'b0;

   // Log of observed writes for literal spot checks.
   logic [BAW-1:0]  l_addr [NE];
   logic [H-1:0]    l_lane [NE];
   logic [H*DW-1:0] l_data [NE];
   int wr_total   = 0;
   int done_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         chk("s_ready_vs_busy", bus.s_ready, bus.busy);
         if (bus.a_wr_en === 1'b1) begin
            if (pop_idx >= push_idx) begin
               chk("unexpected_write", bus.a_wr_en, 1'b0);
            end else begin
               chk("wr_addr", bus.a_wr_addr, e_addr[pop_idx]);
               chk("wr_lane", bus.a_wr_lane_en, e_lane[pop_idx]);
               chk("wr_data", bus.a_wr_data, e_data[pop_idx]);
               chk("done_with_write", bus.done, e_fin[pop_idx]);
               chk("busy_with_write", bus.busy, !e_fin[pop_idx]);
               chk("err_with_write", bus.err, e_err[pop_idx]);
               pop_idx++;
            end
            l_addr[wr_total] = bus.a_wr_addr;
            l_lane[wr_total] = bus.a_wr_lane_en;
            l_data[wr_total] = bus.a_wr_data;
            wr_total++;
         end else if (bus.done === 1'b1 && !allow_done) begin
            chk("spurious_done", bus.done, 1'b0);
         end
         if (bus.done === 1'b1) done_total++;
      end
   endtask

   task automatic do_start(input int m, input int n);
      @(posedge clk); #1;
      bus.start_i = 1'b1;
      bus.m_i     = 16'(m);
      bus.n_i     = 16'(n);
      if (m != 0 && n != 0) model_err = 1'b0;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
   endtask

   // Streams elements 1..m*n. last_beat = 0 puts s_last on the true final beat,
   // otherwise only on that 1-based beat. mid_start/stop_after are 0 when unused.
   task automatic stream(input int m, input int n, input bit gap, input int last_beat,
                         input int mid_start, input int stop_after);
      int total;
      total = m * n;
      for (int k = 0; k < total; k++) begin
         int r, c;
         logic lst, fin;
         logic [H*DW-1:0] d;
         if (stop_after != 0 && k == stop_after) break;
         if (gap) begin
            for (int g = 0; g < 4 && $urandom_range(0, 2) == 0; g++) begin
               bus.s_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         r   = k / n;
         c   = k % n;
         fin = (k == total - 1);
         lst = (last_beat == 0) ? fin : (k + 1 == last_beat);
         if (lst != fin) model_err = 1'b1;
         for (int l = 0; l < H; l++) d[l*DW +: DW] = DW'(k + 1);
         e_addr[push_idx] = BAW'((r / H) * n + c);
         e_lane[push_idx] = H'(1 << (r % H));
         e_data[push_idx] = d;
         e_fin[push_idx]  = fin;
         e_err[push_idx]  = model_err;
         push_idx++;
         chk("s_ready_in_load", bus.s_ready, 1'b1);
         bus.s_valid = 1'b1;
         bus.s_data  = DW'(k + 1);
         bus.s_last  = lst;
         if (mid_start != 0 && k == mid_start) begin
            bus.start_i = 1'b1;
            bus.m_i     = 16'd1;
            bus.n_i     = 16'd1;
         end
         @(posedge clk); #1;
         bus.start_i = 1'b0;
         bus.s_valid = 1'b0;
         bus.s_last  = 1'b0;
      end
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, d0;
      fork
         compare_loop();
      join_none

      bus.start_i = 1'b0;
      bus.m_i     = '0;
      bus.n_i     = '0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_ready", bus.s_ready, 1'b0);
      chk("rst_wr_en", bus.a_wr_en, 1'b0);
      chk("rst_wr_addr", bus.a_wr_addr, '0);
      chk("rst_wr_data", bus.a_wr_data, '0);
      chk("rst_lane_en", bus.a_wr_lane_en, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      reset = 1'b0;

      // 4x4 with continuous valid.
      b = wr_total; d0 = done_total;
      do_start(4, 4);
      chk("busy_after_start", bus.busy, 1'b1);
      stream(4, 4, 1'b0, 0, 0, 0);
      settle();
      chk("s1_writes", 32'(wr_total - b), 32'd16);
      chk("s1_done_cnt", 32'(done_total - d0), 32'd1);
      chk("s1_err", bus.err, 1'b0);
      chk("s1_first_addr", l_addr[b], 10'd0);
      chk("s1_first_lane", l_lane[b], 4'b0001);
      chk("s1_el6_addr", l_addr[b+5], 10'd1);
      chk("s1_el6_lane", l_lane[b+5], 4'b0010);
      chk("s1_el16_data", l_data[b+15], 64'h0010_0010_0010_0010);

      // 8x3: second row group starts at word 3.
      b = wr_total; d0 = done_total;
      do_start(8, 3);
      stream(8, 3, 1'b0, 0, 0, 0);
      settle();
      chk("s2_writes", 32'(wr_total - b), 32'd24);
      chk("s2_done_cnt", 32'(done_total - d0), 32'd1);
      chk("s2_el13_addr", l_addr[b+12], 10'd3);
      chk("s2_el13_lane", l_lane[b+12], 4'b0001);
      chk("s2_el24_addr", l_addr[b+23], 10'd5);
      chk("s2_el24_lane", l_lane[b+23], 4'b1000);

      // 4x4 with random valid gaps.
      b = wr_total; d0 = done_total;
      do_start(4, 4);
      stream(4, 4, 1'b1, 0, 0, 0);
      settle();
      chk("s3_writes", 32'(wr_total - b), 32'd16);
      chk("s3_done_cnt", 32'(done_total - d0), 32'd1);
      chk("s3_el16_addr", l_addr[b+15], 10'd3);
      chk("s3_el16_lane", l_lane[b+15], 4'b1000);

      // s_last on beat 5 only: err from that write on, load still completes.
      b = wr_total; d0 = done_total;
      do_start(4, 4);
      stream(4, 4, 1'b0, 5, 0, 0);
      settle();
      chk("s4_writes", 32'(wr_total - b), 32'd16);
      chk("s4_done_cnt", 32'(done_total - d0), 32'd1);
      chk("s4_err_held", bus.err, 1'b1);
      do_start(4, 4);
      chk("s4_err_cleared", bus.err, 1'b0);
      stream(4, 4, 1'b0, 0, 0, 0);
      settle();

      // Zero-size start.
      b = wr_total; d0 = done_total;
      allow_done = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b1;
      bus.m_i     = 16'd0;
      bus.n_i     = 16'd4;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      chk("z_done", bus.done, 1'b1);
      chk("z_busy", bus.busy, 1'b0);
      chk("z_s_ready", bus.s_ready, 1'b0);
      @(posedge clk); #1;
      chk("z_done_pulse", bus.done, 1'b0);
      allow_done = 1'b0;
      settle();
      chk("z_writes", 32'(wr_total - b), 32'd0);
      chk("z_done_cnt", 32'(done_total - d0), 32'd1);

      // Start pulsed mid-load is ignored.
      b = wr_total; d0 = done_total;
      do_start(4, 4);
      stream(4, 4, 1'b0, 0, 6, 0);
      settle();
      chk("m_writes", 32'(wr_total - b), 32'd16);
      chk("m_done_cnt", 32'(done_total - d0), 32'd1);

      // Reset after beat 7.
      b = wr_total; d0 = done_total;
      do_start(4, 4);
      stream(4, 4, 1'b0, 0, 0, 7);
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      chk("r_s_ready", bus.s_ready, 1'b0);
      chk("r_wr_en", bus.a_wr_en, 1'b0);
      chk("r_wr_addr", bus.a_wr_addr, '0);
      chk("r_wr_data", bus.a_wr_data, '0);
      chk("r_lane_en", bus.a_wr_lane_en, '0);
      chk("r_busy", bus.busy, 1'b0);
      chk("r_done", bus.done, 1'b0);
      chk("r_err", bus.err, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      settle();
      chk("r_writes", 32'(wr_total - b), 32'd7);
      chk("r_no_done", 32'(done_total - d0), 32'd0);
      b = wr_total;
      do_start(4, 4);
      stream(4, 4, 1'b0, 0, 0, 0);
      settle();
      chk("r2_first_addr", l_addr[b], 10'd0);
      chk("r2_first_lane", l_lane[b], 4'b0001);
      chk("r2_writes", 32'(wr_total - b), 32'd16);

      chk("all_writes_seen", 32'(pop_idx), 32'(push_idx));
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
